// File: rtl/sic_dispatch.sv
// Dispatch stage: in-order packet FIFO feeding one idle SIC per cycle, chosen
// round-robin, with each dispatched packet stamped by a wrapping issue id.
package sic_dispatch_pkg;
  localparam int SIC_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [SIC_ID_W-1:0] issue_id;
  } sic_packet_t;
endpackage

module sic_dispatch
  import sic_dispatch_pkg::*;
#(
  parameter int NUM_SIC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  sic_packet_t                     in_pkt,
  output logic                            in_ready,
  input  logic                            flush,
  input  logic [NUM_SIC-1:0]              sic_req_instr,
  output sic_packet_t [NUM_SIC-1:0]       sic_pkt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [ID_WIDTH-1:0]             next_issue_id
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int RW = $clog2(NUM_SIC);

  sic_packet_t               r_mem [FIFO_DEPTH];
  logic [PW-1:0]             r_rd, r_wr;
  logic [CW-1:0]             r_cnt;
  logic [RW-1:0]             r_rr;
  logic [ID_WIDTH-1:0]       r_id;
  sic_packet_t [NUM_SIC-1:0] r_pkt;

  logic        w_push, w_pop, w_gnt_vld;
  logic [RW-1:0] w_gnt;
  sic_packet_t w_out;

  function automatic logic [RW-1:0] rr_idx(input logic [RW-1:0] base, input int k);
    return RW'((int'(base) + k) % NUM_SIC);
  endfunction

  // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
  assign in_ready      = rst_n && (r_cnt < CW'(FIFO_DEPTH));
  assign w_push        = in_valid && in_ready && !flush;
  assign w_pop         = w_gnt_vld;
  assign fifo_count    = r_cnt;
  assign next_issue_id = r_id;
  assign sic_pkt       = r_pkt;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_rr;
    if (r_cnt != '0 && !flush) begin
      for (int k = 1; k <= NUM_SIC; k++) begin
        if (!w_gnt_vld && sic_req_instr[rr_idx(r_rr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = rr_idx(r_rr, k);
        end
      end
    end
  end

  // The stamp field is fixed-width; the counter is resized into it.
  always_comb begin
    w_out          = r_mem[r_rd];
    w_out.valid    = 1'b1;
    w_out.issue_id = SIC_ID_W'(r_id);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_rr  <= RW'(NUM_SIC-1);
      r_id  <= '0;
      r_pkt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_pkt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= in_pkt;
        r_wr        <= r_wr + 1'b1;
      end
      r_pkt <= '0;
      if (w_pop) begin
        r_pkt[w_gnt] <= w_out;
        r_rd         <= r_rd + 1'b1;
        r_rr         <= w_gnt;
        r_id         <= r_id + 1'b1;
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_sic_dispatch.sv
// Directed test of sic_dispatch: fill/full, round-robin order, no-bypass,
// flush, issue-id wrap and mid-stream reset.
module tb_sic_dispatch;
  import sic_dispatch_pkg::*;

  localparam int NS = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  sic_packet_t           in_pkt;
  logic                  in_ready;
  logic                  flush;
  logic [NS-1:0]         sic_req_instr;
  sic_packet_t [NS-1:0]  sic_pkt;
  logic [2:0]            fifo_count;
  logic [7:0]            next_issue_id;

  int total = 0;
  int fails = 0;
  int ndisp = 0;

  sic_dispatch #(.NUM_SIC(NS), .FIFO_DEPTH(4), .ID_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pkt(in_pkt),
    .in_ready(in_ready), .flush(flush), .sic_req_instr(sic_req_instr),
    .sic_pkt(sic_pkt), .fifo_count(fifo_count), .next_issue_id(next_issue_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nvalid();
    logic [31:0] n = 0;
    for (int i = 0; i < NS; i++) n += {31'b0, sic_pkt[i].valid};
    return n;
  endfunction

  // Index of the single valid output, or 15 if none.
  function automatic logic [31:0] vidx();
    logic [31:0] r = 15;
    for (int i = 0; i < NS; i++) if (sic_pkt[i].valid) r = i;
    return r;
  endfunction

  task automatic chk_disp(input string tag, input int idx, input logic [31:0] pc, input logic [31:0] id);
    chk({tag, ".nvalid"}, nvalid(), 1);
    chk({tag, ".sic"}, vidx(), idx);
    chk({tag, ".pc"}, sic_pkt[idx].pc, pc);
    chk({tag, ".id"}, {24'b0, sic_pkt[idx].issue_id}, id);
  endtask

  task automatic push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pkt   = '0;
    in_pkt.pc    = pc;
    in_pkt.instr = pc ^ 32'hA5A5_0000;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pkt = '0; flush = 1'b0; sic_req_instr = '0;
    tick(); tick();
    chk("rst.count", {29'b0, fifo_count}, 0);
    chk("rst.id", {24'b0, next_issue_id}, 0);
    chk("rst.ready", {31'b0, in_ready}, 0);
    chk("rst.pkt_zero", {31'b0, |sic_pkt}, 0);

    rst_n = 1'b1;
    #1 chk("ready_after_rst", {31'b0, in_ready}, 1);
    push(32'h100); push(32'h104); push(32'h108);
    chk("fill3.count", {29'b0, fifo_count}, 3);
    chk("fill3.pkt_zero", {31'b0, |sic_pkt}, 0);
    chk("fill3.ready", {31'b0, in_ready}, 1);
    push(32'h10C);
    chk("full.count", {29'b0, fifo_count}, 4);
    chk("full.ready", {31'b0, in_ready}, 0);

    // push attempt while full together with a pop: push dropped
    in_valid = 1'b1; in_pkt = '0; in_pkt.pc = 32'h200; sic_req_instr = 4'hF;
    tick();
    in_valid = 1'b0;
    chk_disp("rr0", 0, 32'h100, 0);
    chk("full_pop.count", {29'b0, fifo_count}, 3);
    tick(); chk_disp("rr1", 1, 32'h104, 1);
    tick(); chk_disp("rr2", 2, 32'h108, 2);
    tick(); chk_disp("rr3", 3, 32'h10C, 3);
    chk("drain.count", {29'b0, fifo_count}, 0);
    tick();
    chk("empty.pkt_zero", {31'b0, |sic_pkt}, 0);

    // requester waiting on empty FIFO; no bypass
    push(32'h300);
    chk("nobypass.pkt_zero", {31'b0, |sic_pkt}, 0);
    tick();
    chk_disp("wait_req", 0, 32'h300, 4);
    sic_req_instr = '0;
    tick();
    chk("pulse.pkt_zero", {31'b0, |sic_pkt}, 0);

    // flush with 2 buffered, simultaneous push and request
    push(32'h400); push(32'h404);
    chk("preflush.count", {29'b0, fifo_count}, 2);
    flush = 1'b1; in_valid = 1'b1; in_pkt = '0; in_pkt.pc = 32'h408; sic_req_instr = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0; sic_req_instr = '0;
    chk("flush.count", {29'b0, fifo_count}, 0);
    chk("flush.pkt_zero", {31'b0, |sic_pkt}, 0);
    chk("flush.id", {24'b0, next_issue_id}, 5);
    push(32'h500);
    sic_req_instr = 4'hF;
    tick();
    sic_req_instr = '0;
    chk_disp("rr_kept", 1, 32'h500, 5);

    // sustained push+pop to bring the id to 255
    sic_req_instr = 4'hF; in_valid = 1'b1; in_pkt = '0;
    for (int i = 0; i < 249; i++) begin
      in_pkt.pc = 32'h1000 + i;
      tick();
      ndisp += int'(nvalid());
      if (i == 100) chk("steady.count", {29'b0, fifo_count}, 1);
    end
    in_valid = 1'b0;
    tick();
    ndisp += int'(nvalid());
    sic_req_instr = '0;
    chk("bulk.ndisp", ndisp, 249);
    chk("bulk.id", {24'b0, next_issue_id}, 255);
    chk("bulk.count", {29'b0, fifo_count}, 0);
    push(32'hA00); push(32'hA04);
    sic_req_instr = 4'hF;
    tick(); chk_disp("wrap255", 3, 32'hA00, 255);
    tick(); chk_disp("wrap0", 0, 32'hA04, 0);
    sic_req_instr = '0;
    chk("wrap.next_id", {24'b0, next_issue_id}, 1);

    // reset mid-stream with pending grant
    push(32'hB00); push(32'hB04); push(32'hB08);
    sic_req_instr = 4'hF; rst_n = 1'b0;
    tick();
    chk("mrst.pkt_zero", {31'b0, |sic_pkt}, 0);
    chk("mrst.count", {29'b0, fifo_count}, 0);
    chk("mrst.id", {24'b0, next_issue_id}, 0);
    chk("mrst.ready", {31'b0, in_ready}, 0);
    rst_n = 1'b1; sic_req_instr = '0;
    push(32'hC00);
    sic_req_instr = 4'hF;
    tick();
    sic_req_instr = '0;
    chk_disp("mrst.first", 0, 32'hC00, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
